// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg -- shared types and helpers for the pe_mac_drain processing element.
//   state_t          : drain FSM states (COMPUTE, DRAIN)
//   extend_product() : sign/zero extension of a raw product to accumulator width
//   sat_max/sat_min  : saturation limits for a given accumulator width
// Helpers work on a MAX_W-bit carrier; callers cast the result to their width.
// ---------------------------------------------------------------------------
package pe_pkg;

  typedef enum logic [0:0] {
    COMPUTE = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] wide_t;

  // Ones in the low w bits.
  function automatic wide_t low_mask(input int w);
    return ~wide_t'(0) >> (MAX_W - w);
  endfunction

  // Extend a pw-bit product held in the low bits of prod.
  function automatic wide_t extend_product(input wide_t prod, input int pw,
                                           input logic is_signed);
    wide_t m;
    logic  sign;
    m    = low_mask(pw);
    sign = |(prod & (wide_t'(1) << (pw - 1)));
    if (is_signed && sign) return prod | ~m;
    return prod & m;
  endfunction

  function automatic wide_t sat_max(input int w, input logic is_signed);
    return is_signed ? low_mask(w - 1) : low_mask(w);
  endfunction

  function automatic wide_t sat_min(input int w, input logic is_signed);
    return is_signed ? (low_mask(w) & ~low_mask(w - 1)) : '0;
  endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// ---------------------------------------------------------------------------
// pe_mac_unit -- combinational multiply, extend, accumulate and overflow detect.
//   a_i, b_i         : operands (DATA_WIDTH)
//   signed_mode_i    : 1 = two's complement, 0 = unsigned
//   acc_i            : current accumulator
//   restart_i        : accumulate onto zero instead of acc_i
//   sum_o            : next accumulator value if the MAC fires
//   ovf_o            : this add overflowed
// Optional macro PE_SATURATE_EN: clamp sum_o to the limit on overflow.
// ---------------------------------------------------------------------------
module pe_mac_unit
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  signed_mode_i,
  input  logic [ACC_WIDTH-1:0]  acc_i,
  input  logic                  restart_i,
  output logic [ACC_WIDTH-1:0]  sum_o,
  output logic                  ovf_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]        a_ext, b_ext, prod;
  logic [ACC_WIDTH-1:0] ext, addend, raw;
  logic                 carry, s_ovf;

  // Low PW bits of the product of extended operands equal the true signed or
  // unsigned product, so one multiplier serves both modes.
  assign a_ext = signed_mode_i ? {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i}
                               : {{DATA_WIDTH{1'b0}}, a_i};
  assign b_ext = signed_mode_i ? {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i}
                               : {{DATA_WIDTH{1'b0}}, b_i};
  assign prod  = a_ext * b_ext;

  assign ext    = ACC_WIDTH'(extend_product({{(MAX_W-PW){1'b0}}, prod}, PW, signed_mode_i));
  assign addend = restart_i ? '0 : acc_i;

  assign {carry, raw} = {1'b0, addend} + {1'b0, ext};
  assign s_ovf = (addend[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                 (raw[ACC_WIDTH-1] != addend[ACC_WIDTH-1]);
  assign ovf_o = signed_mode_i ? s_ovf : carry;

`ifdef PE_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'(sat_max(ACC_WIDTH, 1'b1));
  localparam logic [ACC_WIDTH-1:0] SMIN = ACC_WIDTH'(sat_min(ACC_WIDTH, 1'b1));
  localparam logic [ACC_WIDTH-1:0] UMAX = ACC_WIDTH'(sat_max(ACC_WIDTH, 1'b0));

  // Signed overflow direction follows the sign both addends shared.
  // Unsigned overflow can only be a carry past the top.
  always_comb begin
    sum_o = raw;
    if (ovf_o) sum_o = signed_mode_i ? (addend[ACC_WIDTH-1] ? SMIN : SMAX) : UMAX;
  end
`else
  assign sum_o = raw;
`endif

endmodule

// File: rtl/pe_mac_drain.sv
// ---------------------------------------------------------------------------
// pe_mac_drain -- output-stationary MAC PE with in-column drain shift chain.
//   in_north_*/in_west_*   : operands + valids; MAC fires when both valid
//   out_south_*/out_east_* : operands + valids forwarded with 1-cycle latency
//   signed_mode            : operand interpretation
//   acc_clear              : first beat of a tile; accumulator restarts
//   drain_start            : column-wide pulse; snapshot acc and shift out
//   drain_in*/drain_out*   : drain chain, north to south
//   busy                   : high while draining
//   overflow               : sticky overflow for the current tile
// Optional macro PE_SATURATE_EN: saturating accumulation (see pe_mac_unit).
// ---------------------------------------------------------------------------
module pe_mac_drain
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ROWS       = 4,
  parameter int ROW_IDX    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_north_data,
  input  logic                  in_north_valid,
  input  logic [DATA_WIDTH-1:0] in_west_data,
  input  logic                  in_west_valid,
  input  logic                  signed_mode,
  input  logic                  acc_clear,
  input  logic                  drain_start,
  output logic [DATA_WIDTH-1:0] out_south_data,
  output logic                  out_south_valid,
  output logic [DATA_WIDTH-1:0] out_east_data,
  output logic                  out_east_valid,
  input  logic [ACC_WIDTH-1:0]  drain_in,
  input  logic                  drain_in_valid,
  output logic [ACC_WIDTH-1:0]  drain_out,
  output logic                  drain_out_valid,
  output logic                  busy,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(ROWS) + 1;
  // A PE must pass on one result from every PE above it (ROW_IDX shifts);
  // the exit edge is itself a shift, so the count loads one less. The top PE
  // still takes one (harmless, invalid) shift.
  localparam int SHIFT_INIT = (ROW_IDX > 0) ? ROW_IDX - 1 : 0;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]  drain_q, drain_d;
  logic                  drain_v_q, drain_v_d;
  logic [DATA_WIDTH-1:0] south_q, east_q;
  logic                  south_v_q, east_v_q;

  logic                  fire, snap, restart, mac_ovf;
  logic [ACC_WIDTH-1:0]  mac_sum;

  assign fire    = in_north_valid && in_west_valid;
  assign snap    = drain_start && (state_q == COMPUTE);
  assign restart = acc_clear || snap;

  pe_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .a_i          (in_north_data),
    .b_i          (in_west_data),
    .signed_mode_i(signed_mode),
    .acc_i        (acc_q),
    .restart_i    (restart),
    .sum_o        (mac_sum),
    .ovf_o        (mac_ovf)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    drain_d   = drain_q;
    drain_v_d = drain_v_q;

    // Accumulation runs in both states so the next tile overlaps the drain.
    if (restart) begin
      acc_d = fire ? mac_sum : '0;
      ovf_d = 1'b0;
    end else if (fire) begin
      acc_d = mac_sum;
      ovf_d = ovf_q | mac_ovf;
    end

    unique case (state_q)
      COMPUTE: begin
        drain_v_d = 1'b0;
        if (drain_start) begin
          drain_d   = acc_q;
          drain_v_d = 1'b1;
          cnt_d     = CNT_W'(SHIFT_INIT);
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        drain_d   = drain_in;
        drain_v_d = drain_in_valid;
        if (cnt_q == '0) state_d = COMPUTE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = COMPUTE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COMPUTE;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      drain_q   <= '0;
      drain_v_q <= 1'b0;
      south_q   <= '0;
      south_v_q <= 1'b0;
      east_q    <= '0;
      east_v_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      drain_q   <= drain_d;
      drain_v_q <= drain_v_d;
      south_q   <= in_north_data;
      south_v_q <= in_north_valid;
      east_q    <= in_west_data;
      east_v_q  <= in_west_valid;
    end
  end

  assign out_south_data  = south_q;
  assign out_south_valid = south_v_q;
  assign out_east_data   = east_q;
  assign out_east_valid  = east_v_q;
  assign drain_out       = drain_q;
  assign drain_out_valid = drain_v_q;
  assign busy            = (state_q == DRAIN);
  assign overflow        = ovf_q;

endmodule
